// File: rtl/decode_execute_reg_if.sv
// Decode-to-execute pipeline boundary: D-stage fields in, registered E-stage fields out.
interface decode_execute_reg_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      StallE;
    logic                      FlushE;
    logic                      ValidD;
    logic                      RegWriteD;
    logic [1:0]                ResultSrcD;
    logic                      MemWriteD;
    logic                      ALUsrcD;
    logic [2:0]                BranchD;
    logic                      JumpD;
    logic [3:0]                ALUControlD;
    logic [2:0]                Funct3D;
    logic [DATA_WIDTH-1:0]     RD1D;
    logic [DATA_WIDTH-1:0]     RD2D;
    logic [DATA_WIDTH-1:0]     ImmExtD;
    logic [DATA_WIDTH-1:0]     PCD;
    logic [DATA_WIDTH-1:0]     PCPlus4D;
    logic [REG_ADDR_WIDTH-1:0] Rs1D;
    logic [REG_ADDR_WIDTH-1:0] Rs2D;
    logic [REG_ADDR_WIDTH-1:0] RdD;

    logic                      ValidE;
    logic                      RegWriteE;
    logic [1:0]                ResultSrcE;
    logic                      MemWriteE;
    logic                      ALUsrcE;
    logic [2:0]                BranchE;
    logic                      JumpE;
    logic [3:0]                ALUControlE;
    logic [2:0]                Funct3E;
    logic [DATA_WIDTH-1:0]     RD1E;
    logic [DATA_WIDTH-1:0]     RD2E;
    logic [DATA_WIDTH-1:0]     ImmExtE;
    logic [DATA_WIDTH-1:0]     PCE;
    logic [DATA_WIDTH-1:0]     PCPlus4E;
    logic [REG_ADDR_WIDTH-1:0] Rs1E;
    logic [REG_ADDR_WIDTH-1:0] Rs2E;
    logic [REG_ADDR_WIDTH-1:0] RdE;
    logic [15:0]               BubbleCountE;

    modport master (
        output StallE, FlushE, ValidD, RegWriteD, ResultSrcD, MemWriteD, ALUsrcD,
               BranchD, JumpD, ALUControlD, Funct3D, RD1D, RD2D, ImmExtD, PCD,
               PCPlus4D, Rs1D, Rs2D, RdD,
        input  ValidE, RegWriteE, ResultSrcE, MemWriteE, ALUsrcE, BranchE, JumpE,
               ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E,
               Rs2E, RdE, BubbleCountE
    );

    modport slave (
        input  StallE, FlushE, ValidD, RegWriteD, ResultSrcD, MemWriteD, ALUsrcD,
               BranchD, JumpD, ALUControlD, Funct3D, RD1D, RD2D, ImmExtD, PCD,
               PCPlus4D, Rs1D, Rs2D, RdD,
        output ValidE, RegWriteE, ResultSrcE, MemWriteE, ALUsrcE, BranchE, JumpE,
               ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E,
               Rs2E, RdE, BubbleCountE
    );
endinterface

// File: rtl/decode_execute_reg.sv
// D->E pipeline register with flush/stall priority, bubble insertion for invalid
// instructions and a saturating count of bubbles loaded.
module decode_execute_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    decode_execute_reg_if.slave bus
);
    typedef struct packed {
        logic                      valid;
        logic                      regwrite;
        logic [1:0]                resultsrc;
        logic                      memwrite;
        logic                      alusrc;
        logic [2:0]                branch;
        logic                      jump;
        logic [3:0]                aluctrl;
        logic [2:0]                funct3;
        logic [DATA_WIDTH-1:0]     rd1;
        logic [DATA_WIDTH-1:0]     rd2;
        logic [DATA_WIDTH-1:0]     imm;
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     pcplus4;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } stage_t;

    stage_t      stage_q, stage_d;
    logic [15:0] bubcnt_q, bubcnt_d;
    logic        load_bubble;

    // An invalid D instruction on a capture edge is treated exactly like a flush.
    assign load_bubble = bus.FlushE || (!bus.StallE && !bus.ValidD);

    always_comb begin
        stage_d  = stage_q;
        bubcnt_d = bubcnt_q;
        if (load_bubble) begin
            stage_d = '0;
            if (bubcnt_q != '1) begin
                bubcnt_d = bubcnt_q + 16'd1;
            end
        end else if (!bus.StallE) begin
            stage_d.valid     = 1'b1;
            stage_d.regwrite  = bus.RegWriteD;
            stage_d.resultsrc = bus.ResultSrcD;
            stage_d.memwrite  = bus.MemWriteD;
            stage_d.alusrc    = bus.ALUsrcD;
            stage_d.branch    = bus.BranchD;
            stage_d.jump      = bus.JumpD;
            stage_d.aluctrl   = bus.ALUControlD;
            stage_d.funct3    = bus.Funct3D;
            stage_d.rd1       = bus.RD1D;
            stage_d.rd2       = bus.RD2D;
            stage_d.imm       = bus.ImmExtD;
            stage_d.pc        = bus.PCD;
            stage_d.pcplus4   = bus.PCPlus4D;
            stage_d.rs1       = bus.Rs1D;
            stage_d.rs2       = bus.Rs2D;
            stage_d.rd        = bus.RdD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q  <= '0;
            bubcnt_q <= '0;
        end else begin
            stage_q  <= stage_d;
            bubcnt_q <= bubcnt_d;
        end
    end

    assign bus.ValidE       = stage_q.valid;
    assign bus.RegWriteE    = stage_q.regwrite;
    assign bus.ResultSrcE   = stage_q.resultsrc;
    assign bus.MemWriteE    = stage_q.memwrite;
    assign bus.ALUsrcE      = stage_q.alusrc;
    assign bus.BranchE      = stage_q.branch;
    assign bus.JumpE        = stage_q.jump;
    assign bus.ALUControlE  = stage_q.aluctrl;
    assign bus.Funct3E      = stage_q.funct3;
    assign bus.RD1E         = stage_q.rd1;
    assign bus.RD2E         = stage_q.rd2;
    assign bus.ImmExtE      = stage_q.imm;
    assign bus.PCE          = stage_q.pc;
    assign bus.PCPlus4E     = stage_q.pcplus4;
    assign bus.Rs1E         = stage_q.rs1;
    assign bus.Rs2E         = stage_q.rs2;
    assign bus.RdE          = stage_q.rd;
    assign bus.BubbleCountE = bubcnt_q;
endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed bench for decode_execute_reg: capture, stall, flush, bubbles, saturation, async reset.
module tb_decode_execute_reg;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_execute_reg_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    decode_execute_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [207:0] e_all;
    assign e_all = {bus.ValidE, bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.ALUsrcE,
                    bus.BranchE, bus.JumpE, bus.ALUControlE, bus.Funct3E, bus.RD1E, bus.RD2E,
                    bus.ImmExtE, bus.PCE, bus.PCPlus4E, bus.Rs1E, bus.Rs2E, bus.RdE,
                    bus.BubbleCountE};

    localparam logic [207:0] CAP_A = {1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 1'b0, 4'b0110,
                                      3'b101, 32'h10, 32'hDEADBEEF, 32'h4, 32'h100, 32'h104,
                                      5'd3, 5'd9, 5'd5, 16'd0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                         input logic as, input logic [2:0] br, input logic j,
                         input logic [3:0] alu, input logic [2:0] f3, input logic [31:0] rd1,
                         input logic [31:0] rd2, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [31:0] pc4, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d);
        bus.ValidD = v; bus.RegWriteD = rw; bus.ResultSrcD = rs; bus.MemWriteD = mw;
        bus.ALUsrcD = as; bus.BranchD = br; bus.JumpD = j; bus.ALUControlD = alu;
        bus.Funct3D = f3; bus.RD1D = rd1; bus.RD2D = rd2; bus.ImmExtD = imm; bus.PCD = pc;
        bus.PCPlus4D = pc4; bus.Rs1D = s1; bus.Rs2D = s2; bus.RdD = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.StallE = 1'b0;
        bus.FlushE = 1'b1;
        set_d(1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 3'b111, 1'b1, 4'hF, 3'h7, '1, '1, '1, '1, '1,
              '1, '1, '1);
        tick();
        checks++;
        if (e_all !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", e_all);
        end
        #2 rst = 1'b0;
        bus.FlushE = 1'b0;
    endtask

    task automatic test_capture();
        set_d(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 1'b0, 4'b0110, 3'b101, 32'h10,
              32'hDEADBEEF, 32'h4, 32'h100, 32'h104, 5'd3, 5'd9, 5'd5);
        tick();
        checks++;
        if (bus.RegWriteE !== 1'b1 || bus.ResultSrcE !== 2'b01 || bus.ValidE !== 1'b1) begin
            errors++;
            $display("FAIL capture_ctrl: got rw=%b rs=%b v=%b expected 1 01 1",
                     bus.RegWriteE, bus.ResultSrcE, bus.ValidE);
        end
        checks++;
        if (bus.RD1E !== 32'h10 || bus.ImmExtE !== 32'h4 || bus.RdE !== 5'd5) begin
            errors++;
            $display("FAIL capture_data: got rd1=%h imm=%h rd=%0d expected 10 4 5",
                     bus.RD1E, bus.ImmExtE, bus.RdE);
        end
        checks++;
        if (e_all !== CAP_A) begin
            errors++;
            $display("FAIL capture_all: got %h expected %h", e_all, CAP_A);
        end
    endtask

    task automatic test_stall();
        bus.StallE = 1'b1;
        bus.RdD = 5'd7;
        bus.RD1D = 32'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (e_all !== CAP_A) begin
                errors++;
                $display("FAIL stall_hold_%0d: got %h expected %h", i, e_all, CAP_A);
            end
        end
        bus.StallE = 1'b0;
        tick();
        checks++;
        if (bus.RdE !== 5'd7 || bus.RD1E !== 32'h77 || bus.BubbleCountE !== 16'd0) begin
            errors++;
            $display("FAIL stall_release: got rd=%0d rd1=%h cnt=%0d expected 7 77 0",
                     bus.RdE, bus.RD1E, bus.BubbleCountE);
        end
    endtask

    task automatic test_back_to_back();
        bus.RD1D = 32'hA1; bus.PCD = 32'h200;
        tick();
        checks++;
        if (bus.RD1E !== 32'hA1 || bus.PCE !== 32'h200) begin
            errors++;
            $display("FAIL b2b_first: got rd1=%h pc=%h expected a1 200", bus.RD1E, bus.PCE);
        end
        bus.RD1D = 32'hB2; bus.PCD = 32'h204;
        tick();
        checks++;
        if (bus.RD1E !== 32'hB2 || bus.PCE !== 32'h204) begin
            errors++;
            $display("FAIL b2b_second: got rd1=%h pc=%h expected b2 204", bus.RD1E, bus.PCE);
        end
    endtask

    task automatic test_flush_over_stall();
        bus.StallE = 1'b1;
        bus.FlushE = 1'b1;
        bus.ValidD = 1'b1;
        bus.JumpD = 1'b1;
        tick();
        checks++;
        if (e_all !== {192'd0, 16'd1}) begin
            errors++;
            $display("FAIL flush_over_stall: got %h expected bubble with count 1", e_all);
        end
        bus.StallE = 1'b0;
        bus.FlushE = 1'b0;
        bus.JumpD = 1'b0;
    endtask

    task automatic test_invalid_capture();
        bus.ValidD = 1'b0;
        bus.MemWriteD = 1'b1;
        bus.RegWriteD = 1'b1;
        tick();
        checks++;
        if (e_all !== {192'd0, 16'd2}) begin
            errors++;
            $display("FAIL invalid_capture: got %h expected bubble with count 2", e_all);
        end
        bus.StallE = 1'b1;
        bus.ValidD = 1'b1;
        tick();
        checks++;
        if (bus.BubbleCountE !== 16'd2 || bus.ValidE !== 1'b0) begin
            errors++;
            $display("FAIL stall_keeps_count: got cnt=%0d v=%b expected 2 0",
                     bus.BubbleCountE, bus.ValidE);
        end
        bus.StallE = 1'b0;
        bus.MemWriteD = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.FlushE = 1'b1;
        repeat (7) tick();
        bus.FlushE = 1'b0;
        bus.ValidD = 1'b1;
        tick();
        checks++;
        if (bus.ValidE !== 1'b1 || bus.BubbleCountE !== 16'd9) begin
            errors++;
            $display("FAIL pre_reset_state: got v=%b cnt=%0d expected 1 9",
                     bus.ValidE, bus.BubbleCountE);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (e_all !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", e_all);
        end
        bus.FlushE = 1'b1;
        tick();
        checks++;
        if (e_all !== '0) begin
            errors++;
            $display("FAIL reset_overrides_flush: got %h expected 0", e_all);
        end
        bus.FlushE = 1'b0;
        bus.RdD = 5'd12;
        #2 rst = 1'b0;
        tick();
        checks++;
        if (bus.ValidE !== 1'b1 || bus.RdE !== 5'd12 || bus.BubbleCountE !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_capture: got v=%b rd=%0d cnt=%0d expected 1 12 0",
                     bus.ValidE, bus.RdE, bus.BubbleCountE);
        end
    endtask

    task automatic test_saturation();
        bus.FlushE = 1'b1;
        repeat (65534) tick();
        checks++;
        if (bus.BubbleCountE !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_preload: got %h expected fffe", bus.BubbleCountE);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.BubbleCountE !== 16'hFFFF) begin
                errors++;
                $display("FAIL sat_flush_%0d: got %h expected ffff", i, bus.BubbleCountE);
            end
        end
        bus.FlushE = 1'b0;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_stall();
        test_back_to_back();
        test_flush_over_stall();
        test_invalid_capture();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
